// File: rtl/vid_pkg.sv
// Shared definitions for the AXI4-Stream video pattern generator: pixel layout,
// pattern encodings, colour-bar table and FSM state type.
package vid_pkg;

  // Component index within a pixel; component c occupies bits [c*C_WIDTH +: C_WIDTH].
  localparam int unsigned COMP_B = 0;
  localparam int unsigned COMP_G = 1;
  localparam int unsigned COMP_R = 2;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  // Per-bar component on/off flags, bit COMP_x set means that component is full scale.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111,  // white
    3'b110,  // yellow
    3'b011,  // cyan
    3'b010,  // green
    3'b101,  // magenta
    3'b100,  // red
    3'b001,  // blue
    3'b000   // black
  };

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/vid_pixel_colour.sv
// Combinational colour of one pixel given the pattern, its column/line, the current
// colour-bar index and the latched solid colour.
module vid_pixel_colour import vid_pkg::*; #(
  parameter int unsigned C_WIDTH = 8,
  parameter int unsigned SQ_LOG2 = 5
) (
  input  pattern_e             pattern_i,
  input  logic [15:0]          x_i,
  input  logic [15:0]          y_i,
  input  logic [2:0]           bar_i,
  input  logic [3*C_WIDTH-1:0] solid_i,
  output logic [3*C_WIDTH-1:0] pixel_o
);

  // Only the low column bits and the square-select bits matter to the patterns.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x_i, y_i};

  always_comb begin
    pixel_o = '0;
    unique case (pattern_i)
      PAT_BARS: begin
        for (int c = 0; c < 3; c++) begin
          pixel_o[c*C_WIDTH +: C_WIDTH] = {C_WIDTH{BAR_RGB[bar_i][c]}};
        end
      end
      PAT_RAMP:  pixel_o = {3{x_i[C_WIDTH-1:0]}};
      PAT_SOLID: pixel_o = solid_i;
      PAT_CHECK: pixel_o = (x_i[SQ_LOG2] ^ y_i[SQ_LOG2]) ? '1 : '0;
      default:   pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream test-pattern source: whole frames, PIXEL_PER_CLK pixels per beat,
// tuser marks start of frame and tlast marks end of line.
module axis_video_pattern_gen import vid_pkg::*; #(
  parameter int unsigned H_ACTIVE      = 1920,
  parameter int unsigned V_ACTIVE      = 1080,
  parameter int unsigned PIXEL_PER_CLK = 4,
  parameter int unsigned C_WIDTH       = 8,
  parameter int unsigned SQ_LOG2       = 5
) (
  input  logic                                 SYS_CLK_I,
  input  logic                                 RESET_N_I,
  input  logic                                 ENABLE_I,
  input  logic [1:0]                           PATTERN_SEL_I,
  input  logic [3*C_WIDTH-1:0]                 SOLID_RGB_I,
  output logic [PIXEL_PER_CLK*3*C_WIDTH-1:0]   tdata_O,
  output logic                                 tvalid_O,
  input  logic                                 tready_I,
  output logic                                 tuser_O,
  output logic                                 tlast_O,
  output logic                                 FRAME_DONE_O,
  output logic [15:0]                          FRAME_CNT_O
);

  localparam int unsigned PW        = 3 * C_WIDTH;
  localparam int unsigned BEATS     = H_ACTIVE / PIXEL_PER_CLK;
  localparam int unsigned BAR_BEATS = BEATS / 8;
  localparam int unsigned XW        = $clog2(BEATS);
  localparam int unsigned YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BW        = (BAR_BEATS > 1) ? $clog2(BAR_BEATS) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(BEATS - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BB_LAST = BW'(BAR_BEATS - 1);

  state_e               state_q;
  pattern_e             pat_q;
  logic [PW-1:0]        solid_q;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [2:0]           bar_q, bar_d;
  logic [BW-1:0]        bar_beat_q, bar_beat_d;
  logic [PIXEL_PER_CLK*PW-1:0] tdata_d;

  logic accept, last_x, last_y, frame_end, start, advance, load;
  pattern_e      pix_pat;
  logic [PW-1:0] pix_solid;

  assign accept    = tvalid_O && tready_I;
  assign last_x    = (x_q == X_LAST);
  assign last_y    = (y_q == Y_LAST);
  assign frame_end = accept && last_x && last_y;
  // A new frame starts from IDLE or straight after the previous frame's last beat.
  assign start     = ENABLE_I && ((state_q == IDLE) || frame_end);
  assign advance   = accept && !(last_x && last_y);
  assign load      = start || advance;

  // The beat loaded at a frame start uses the settings being latched on that same edge.
  assign pix_pat   = start ? pattern_e'(PATTERN_SEL_I) : pat_q;
  assign pix_solid = start ? SOLID_RGB_I : solid_q;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    bar_d      = bar_q;
    bar_beat_d = bar_beat_q;
    if (start) begin
      x_d        = '0;
      y_d        = '0;
      bar_d      = '0;
      bar_beat_d = '0;
    end else if (advance) begin
      if (last_x) begin
        x_d        = '0;
        y_d        = y_q + 1'b1;
        bar_d      = '0;
        bar_beat_d = '0;
      end else begin
        x_d = x_q + 1'b1;
        if (bar_beat_q == BB_LAST) begin
          bar_beat_d = '0;
          bar_d      = bar_q + 1'b1;
        end else begin
          bar_beat_d = bar_beat_q + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < PIXEL_PER_CLK; k++) begin : g_pix
    logic [15:0] col;
    assign col = 16'(x_d) * 16'(PIXEL_PER_CLK) + 16'(k);

    vid_pixel_colour #(
      .C_WIDTH (C_WIDTH),
      .SQ_LOG2 (SQ_LOG2)
    ) u_pix (
      .pattern_i (pix_pat),
      .x_i       (col),
      .y_i       (16'(y_d)),
      .bar_i     (bar_d),
      .solid_i   (pix_solid),
      .pixel_o   (tdata_d[k*PW +: PW])
    );
  end

  always_ff @(posedge SYS_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      state_q      <= IDLE;
      pat_q        <= PAT_BARS;
      solid_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      bar_q        <= '0;
      bar_beat_q   <= '0;
      tdata_O      <= '0;
      tvalid_O     <= 1'b0;
      tuser_O      <= 1'b0;
      tlast_O      <= 1'b0;
      FRAME_DONE_O <= 1'b0;
      FRAME_CNT_O  <= '0;
    end else begin
      FRAME_DONE_O <= frame_end;
      if (frame_end) begin
        FRAME_CNT_O <= FRAME_CNT_O + 16'd1;
      end
      if (start) begin
        state_q <= ACTIVE;
        pat_q   <= pattern_e'(PATTERN_SEL_I);
        solid_q <= SOLID_RGB_I;
      end else if (frame_end) begin
        state_q <= IDLE;
      end
      if (load) begin
        x_q        <= x_d;
        y_q        <= y_d;
        bar_q      <= bar_d;
        bar_beat_q <= bar_beat_d;
        tdata_O    <= tdata_d;
        tvalid_O   <= 1'b1;
        tuser_O    <= start;
        tlast_O    <= (x_d == X_LAST);
      end else if (frame_end) begin
        tvalid_O <= 1'b0;
        tuser_O  <= 1'b0;
        tlast_O  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed/randomized bench for axis_video_pattern_gen against a frame-level pixel model.
module tb_axis_video_pattern_gen;

  localparam int H     = 64;
  localparam int V     = 8;
  localparam int PPC   = 4;
  localparam int BPL   = H / PPC;
  localparam int FRAME = BPL * V;

  typedef struct packed {
    logic [1:0]  pat;
    logic [23:0] solid;
  } frame_cfg_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pat;
  logic [23:0] solid;
  logic [95:0] tdata;
  logic        tvalid, tready, tuser, tlast, frame_done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  axis_video_pattern_gen #(
    .H_ACTIVE      (H),
    .V_ACTIVE      (V),
    .PIXEL_PER_CLK (PPC),
    .C_WIDTH       (8),
    .SQ_LOG2       (2)
  ) dut (
    .SYS_CLK_I     (clk),
    .RESET_N_I     (rst_n),
    .ENABLE_I      (en),
    .PATTERN_SEL_I (pat),
    .SOLID_RGB_I   (solid),
    .tdata_O       (tdata),
    .tvalid_O      (tvalid),
    .tready_I      (tready),
    .tuser_O       (tuser),
    .tlast_O       (tlast),
    .FRAME_DONE_O  (frame_done),
    .FRAME_CNT_O   (frame_cnt)
  );

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          passed = 0;
  int          total = 0;
  int          accepted = 0;
  int          cyc = 0;
  int          beat_n = 0;
  logic [15:0] exp_cnt = '0;
  bit          fin_pend = 0;
  bit          hold_pend = 0;
  logic [97:0] hold_val;
  frame_cfg_t  cfg_q[$];
  frame_cfg_t  cur_cfg;

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected beat n (0-based within frame) built from the pattern rules.
  function automatic logic [95:0] exp_beat(frame_cfg_t cfg, int n);
    int          line = n / BPL;
    int          xb = n % BPL;
    logic [95:0] r = '0;
    logic [23:0] px;
    logic [7:0]  c8;
    for (int k = 0; k < PPC; k++) begin
      int col = PPC * xb + k;
      c8 = col[7:0];
      case (cfg.pat)
        2'd0:    px = bars[col / (H / 8)];
        2'd1:    px = {c8, c8, c8};
        2'd2:    px = cfg.solid;
        default: px = (((col / 4) + (line / 4)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      endcase
      r[24*k +: 24] = px;
    end
    return r;
  endfunction

  // One clock: check at the falling edge, return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    chk("frame_done", {95'd0, frame_done}, {95'd0, fin_pend});
    chk("frame_cnt", {80'd0, frame_cnt}, {80'd0, exp_cnt});
    fin_pend = 0;
    if (hold_pend) chk("hold_stable", {tdata, tuser, tlast}, hold_val);
    hold_pend = tvalid && !tready;
    hold_val  = {tdata, tuser, tlast};
    if (tvalid && tready) begin
      if (beat_n == 0) begin
        chk("frame_expected", {95'd0, cfg_q.size() > 0}, 96'd1);
        if (cfg_q.size() > 0) cur_cfg = cfg_q.pop_front();
      end
      chk("tdata", tdata, exp_beat(cur_cfg, beat_n));
      chk("tuser", {95'd0, tuser}, {95'd0, beat_n == 0});
      chk("tlast", {95'd0, tlast}, {95'd0, (beat_n % BPL) == BPL - 1});
      if (beat_n == FRAME - 1) begin
        fin_pend = 1;
        exp_cnt  = exp_cnt + 16'd1;
      end
      beat_n = (beat_n + 1) % FRAME;
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepted(int target, int budget);
    int n = 0;
    while (accepted < target && n < budget) begin
      cycle();
      n++;
    end
    chk("beats_accepted", 96'(accepted), 96'(target));
  endtask

  initial begin
    int base, c0;
    rst_n = 1'b0; en = 1'b0; pat = 2'd0; solid = 24'h0; tready = 1'b1;
    cycle();
    cycle();
    chk("rst_outputs", {tdata, tvalid, tuser, tlast}, '0);
    chk("rst_done_cnt", {79'd0, frame_done, frame_cnt}, '0);
    rst_n = 1'b1;
    cycle();

    // Colour bars, single-cycle enable pulse: exactly one frame then idle.
    base = accepted;
    pat = 2'd0; cfg_q.push_back('{2'd0, 24'h0});
    en = 1'b1; cycle(); en = 1'b0;
    wait_accepted(base + FRAME, 3 * FRAME);
    repeat (4) cycle();
    chk("bars_no_extra", 96'(accepted), 96'(base + FRAME));
    chk("bars_idle", {95'd0, tvalid}, 96'd0);
    chk("bars_cnt", {80'd0, frame_cnt}, 96'd1);

    // Grey ramp under random back-pressure.
    base = accepted;
    pat = 2'd1; cfg_q.push_back('{2'd1, 24'h0});
    en = 1'b1; cycle(); en = 1'b0;
    c0 = 0;
    while (accepted < base + FRAME && c0 < 20 * FRAME) begin
      tready = 1'($urandom_range(0, 1));
      cycle();
      c0++;
    end
    chk("ramp_beats", 96'(accepted), 96'(base + FRAME));
    tready = 1'b1;
    repeat (3) cycle();
    chk("ramp_idle", {95'd0, tvalid}, 96'd0);

    // Three back-to-back frames with enable held: no bubbles between frames.
    base = accepted;
    pat = 2'd0;
    repeat (3) cfg_q.push_back('{2'd0, 24'h0});
    c0 = cyc;
    en = 1'b1;
    wait_accepted(base + 2 * FRAME + 10, 4 * FRAME);
    en = 1'b0;
    wait_accepted(base + 3 * FRAME, 2 * FRAME);
    chk("gapless_cycles", 96'(cyc - c0), 96'(3 * FRAME + 1));
    repeat (3) cycle();
    chk("b2b_idle", {95'd0, tvalid}, 96'd0);
    chk("b2b_cnt", {80'd0, frame_cnt}, 96'd5);

    // Solid colour changed mid-frame only takes effect on the next frame.
    base = accepted;
    pat = 2'd2; solid = 24'h123456;
    cfg_q.push_back('{2'd2, 24'h123456});
    cfg_q.push_back('{2'd2, 24'hABCDEF});
    en = 1'b1;
    wait_accepted(base + 20, 2 * FRAME);
    solid = 24'hABCDEF;
    pat = 2'd1;
    wait_accepted(base + FRAME - 5, 2 * FRAME);
    pat = 2'd2;
    wait_accepted(base + FRAME + 10, 2 * FRAME);
    en = 1'b0;
    wait_accepted(base + 2 * FRAME, 2 * FRAME);
    repeat (3) cycle();
    chk("solid_cnt", {80'd0, frame_cnt}, 96'd7);

    // Checkerboard with 4-pixel squares.
    base = accepted;
    pat = 2'd3; cfg_q.push_back('{2'd3, 24'h0});
    en = 1'b1; cycle(); en = 1'b0;
    wait_accepted(base + FRAME, 3 * FRAME);
    repeat (3) cycle();
    chk("check_cnt", {80'd0, frame_cnt}, 96'd8);

    // Reset in the middle of a frame, then restart cleanly.
    base = accepted;
    pat = 2'd1; cfg_q.push_back('{2'd1, 24'h0});
    en = 1'b1; cycle(); en = 1'b0;
    wait_accepted(base + 30, 3 * FRAME);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {tdata, tvalid, tuser, tlast}, '0);
    cfg_q.delete();
    beat_n = 0; exp_cnt = '0; fin_pend = 0; hold_pend = 0;
    en = 1'b1;
    cycle();
    chk("rst_hold_tvalid", {95'd0, tvalid}, 96'd0);
    chk("rst_hold_cnt", {80'd0, frame_cnt}, 96'd0);
    rst_n = 1'b1;
    cfg_q.push_back('{2'd1, 24'h0});
    cycle();
    en = 1'b0;
    chk("restart_tvalid", {95'd0, tvalid}, 96'd1);
    chk("restart_tuser", {95'd0, tuser}, 96'd1);
    chk("restart_tdata", tdata, exp_beat('{2'd1, 24'h0}, 0));
    chk("restart_cnt", {80'd0, frame_cnt}, 96'd0);
    base = accepted;
    wait_accepted(base + FRAME, 3 * FRAME);
    repeat (3) cycle();
    chk("restart_idle", {95'd0, tvalid}, 96'd0);
    chk("restart_final_cnt", {80'd0, frame_cnt}, 96'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
